// File: rtl/fpu_divsqrt_iter.sv
// Iterative radix-2 restoring FP divide / square root, one result bit per cycle, RNE, FTZ.
// Optional macro FPU_DIVSQRT_ABORT_EN adds an i_abort input that cancels an operation.
module fpu_divsqrt_iter #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
`ifdef FPU_DIVSQRT_ABORT_EN
  input  logic                   i_abort,
`endif
  input  logic                   i_start,
  input  logic                   i_op,
  input  logic [EXP_W+MAN_W:0]   i_data1,
  input  logic [EXP_W+MAN_W:0]   i_data2,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic [EXP_W+MAN_W:0]   o_result,
  output logic [4:0]             o_flags
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned N  = MAN_W + 4;
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned RW = N + 3;
  localparam int unsigned CW = $clog2(N);
  localparam logic signed [EW-1:0] BIAS = EW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [4:0] F_NV = 5'b10000, F_DZ = 5'b01000, F_OF = 5'b00100,
                         F_UF = 5'b00010, F_NX = 5'b00001;

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StRound, StDone} state_t;

  state_t                 r_state;
  logic                   r_op, r_sign;
  logic [W-1:0]           r_a, r_b, r_pres;
  logic [4:0]             r_pflg;
  logic signed [EW-1:0]   r_exp;
  logic [RW-1:0]          r_rem;
  logic [2*N-1:0]         r_rad;
  logic [N-1:0]           r_q;
  logic [CW-1:0]          r_cnt;

  logic w_abort;
`ifdef FPU_DIVSQRT_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // Operand decode; exponent field 0 covers subnormals, which flush to signed zero.
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic w_sa, w_sx, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  assign w_sa = r_a[W-1];
  assign w_sx = r_a[W-1] ^ r_b[W-1];
  assign w_ea = r_a[W-2:MAN_W];
  assign w_eb = r_b[W-2:MAN_W];
  assign w_fa = r_a[MAN_W-1:0];
  assign w_fb = r_b[MAN_W-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) & ~(|w_fa);
  assign w_b_inf  = (&w_eb) & ~(|w_fb);
  assign w_a_nan  = (&w_ea) & (|w_fa);
  assign w_b_nan  = (&w_eb) & (|w_fb);
  assign w_a_snan = w_a_nan & ~w_fa[MAN_W-1];
  assign w_b_snan = w_b_nan & ~w_fb[MAN_W-1];

  logic signed [EW-1:0] w_ea_s, w_eb_s, w_eu, w_exp_div, w_exp_sqrt;
  logic [MAN_W+1:0]     w_msq;
  assign w_ea_s     = $signed({2'b00, w_ea});
  assign w_eb_s     = $signed({2'b00, w_eb});
  assign w_eu       = w_ea_s - BIAS;
  assign w_exp_div  = w_ea_s - w_eb_s + BIAS;
  assign w_exp_sqrt = (w_eu >>> 1) + BIAS;
  // An odd unbiased exponent moves one factor of two into the radicand.
  assign w_msq      = w_eu[0] ? {1'b1, w_fa, 1'b0} : {2'b01, w_fa};

  logic           w_special;
  logic [W-1:0]   w_sp_res;
  logic [4:0]     w_sp_flg;
  always_comb begin
    w_special = 1'b1;
    w_sp_res  = QNAN;
    w_sp_flg  = '0;
    if (r_op) begin
      if (w_a_snan)      w_sp_flg = F_NV;
      else if (w_a_nan)  w_sp_flg = '0;
      else if (w_a_zero) w_sp_res = {w_sa, {(W-1){1'b0}}};
      else if (w_sa)     w_sp_flg = F_NV;
      else if (w_a_inf)  w_sp_res = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else               w_special = 1'b0;
    end else begin
      if (w_a_snan | w_b_snan)                              w_sp_flg = F_NV;
      else if (w_a_nan | w_b_nan)                           w_sp_flg = '0;
      else if ((w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) w_sp_flg = F_NV;
      else if (w_a_inf) w_sp_res = {w_sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (w_b_inf) w_sp_res = {w_sx, {(W-1){1'b0}}};
      else if (w_b_zero) begin
        w_sp_res = {w_sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        w_sp_flg = F_DZ;
      end
      else if (w_a_zero) w_sp_res = {w_sx, {(W-1){1'b0}}};
      else               w_special = 1'b0;
    end
  end

  // One restoring step: divisor or trial root {root, 01} against the partial remainder.
  logic [RW-1:0] w_rem_in, w_trial, w_rem_nx;
  logic          w_ge;
  assign w_rem_in = r_op ? {r_rem[N:0], r_rad[2*N-1 -: 2]} : r_rem;
  assign w_trial  = r_op ? {1'b0, r_q, 2'b01}
                         : {{(RW-MAN_W-1){1'b0}}, 1'b1, w_fb};
  assign w_ge     = (w_rem_in >= w_trial);
  assign w_rem_nx = w_ge ? (w_rem_in - w_trial) : w_rem_in;

  // Quotient below 1 needs one left shift; the root is always in [1,2).
  logic                 w_norm, w_guard, w_sticky, w_up;
  logic [MAN_W:0]       w_sig;
  logic [MAN_W+1:0]     w_sig_r;
  logic [MAN_W-1:0]     w_man;
  logic signed [EW-1:0] w_exp_r;
  logic [W-1:0]         w_rd_res;
  logic [4:0]           w_rd_flg;
  assign w_norm   = ~r_op & ~r_q[N-1];
  assign w_sig    = w_norm ? r_q[N-2:2] : r_q[N-1:3];
  assign w_guard  = w_norm ? r_q[1] : r_q[2];
  assign w_sticky = (w_norm ? r_q[0] : |r_q[1:0]) | (|r_rem);
  assign w_up     = w_guard & (w_sticky | w_sig[0]);
  assign w_sig_r  = {1'b0, w_sig} + {{(MAN_W+1){1'b0}}, w_up};
  assign w_man    = w_sig_r[MAN_W+1] ? w_sig_r[MAN_W:1] : w_sig_r[MAN_W-1:0];
  assign w_exp_r  = r_exp - $signed({{(EW-1){1'b0}}, w_norm})
                          + $signed({{(EW-1){1'b0}}, w_sig_r[MAN_W+1]});

  always_comb begin
    w_rd_res = {r_sign, w_exp_r[EXP_W-1:0], w_man};
    w_rd_flg = {4'b0000, w_guard | w_sticky};
    if (w_exp_r >= EMAX) begin
      w_rd_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_rd_flg = F_OF | F_NX;
    end else if (w_exp_r[EW-1] || (w_exp_r == '0)) begin
      w_rd_res = {r_sign, {(W-1){1'b0}}};
      w_rd_flg = F_UF | F_NX;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= StIdle;
      r_op     <= 1'b0;
      r_sign   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_pres   <= '0;
      r_pflg   <= '0;
      r_exp    <= '0;
      r_rem    <= '0;
      r_rad    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_flags  <= '0;
    end else begin
      o_valid <= 1'b0;
      if (w_abort && (r_state != StIdle)) begin
        r_state <= StIdle;
        o_busy  <= 1'b0;
      end else begin
        case (r_state)
          StIdle: if (i_start) begin
            r_op    <= i_op;
            r_a     <= i_data1;
            r_b     <= i_data2;
            o_busy  <= 1'b1;
            r_state <= StPrep;
          end
          StPrep: if (w_special) begin
            r_pres  <= w_sp_res;
            r_pflg  <= w_sp_flg;
            r_state <= StDone;
          end else begin
            r_sign  <= r_op ? 1'b0 : w_sx;
            r_exp   <= r_op ? w_exp_sqrt : w_exp_div;
            r_rem   <= r_op ? '0 : {{(RW-MAN_W-1){1'b0}}, 1'b1, w_fa};
            r_rad   <= {w_msq, {(MAN_W+6){1'b0}}};
            r_q     <= '0;
            r_cnt   <= CW'(N - 1);
            r_state <= StIter;
          end
          StIter: begin
            r_q   <= {r_q[N-2:0], w_ge};
            r_rad <= {r_rad[2*N-3:0], 2'b00};
            r_rem <= r_op ? w_rem_nx : {w_rem_nx[RW-2:0], 1'b0};
            if (r_cnt == '0) r_state <= StRound;
            else             r_cnt   <= r_cnt - CW'(1);
          end
          StRound: begin
            r_pres  <= w_rd_res;
            r_pflg  <= w_rd_flg;
            r_state <= StDone;
          end
          StDone: begin
            o_result <= r_pres;
            o_flags  <= r_pflg;
            o_valid  <= 1'b1;
            o_busy   <= 1'b0;
            r_state  <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpu_divsqrt_iter.sv
// Scoreboard bench for fpu_divsqrt_iter: directed binary32 vectors, latency and handshake checks.
module tb_fpu_divsqrt_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] d1 = '0, d2 = '0;
  logic        busy, valid;
  logic [31:0] result;
  logic [4:0]  flags;
`ifdef FPU_DIVSQRT_ABORT_EN
  logic        abort = 1'b0;
`endif

  fpu_divsqrt_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .i_clk    (clk),
    .i_reset  (rst),
`ifdef FPU_DIVSQRT_ABORT_EN
    .i_abort  (abort),
`endif
    .i_start  (start),
    .i_op     (op),
    .i_data1  (d1),
    .i_data2  (d2),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_result (result),
    .o_flags  (flags)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_res = '0;
  int          busy_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got result %h flags %h, none expected", result, flags);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("flags", {27'd0, flags}, {27'd0, e.flg});
        check("latency", cyc, e.at);
        check("busy_at_valid", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Call at a falling edge with the unit idle; returns one falling edge later.
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [4:0] f, input int unsigned lat);
    start = 1'b1;
    op    = o;
    d1    = a;
    d2    = b;
    sb.push_back('{res: r, flg: f, at: cyc + 1 + lat});
    last_res = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d results pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic [4:0] f, input int unsigned lat);
    issue(o, a, b, r, f, lat);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {27'd0, flags}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 6 / 2 with BUSY held for the 29 cycles before VALID
    issue(1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 30);
    busy_cnt = 0;
    for (int i = 0; i < 29; i++) begin
      if (busy && !valid) busy_cnt++;
      @(negedge clk);
    end
    check("busy_hold", busy_cnt, 32'd29);
    drain();

    run(1'b1, 32'h40000000, 32'h0,        32'h3FB504F3, 5'h01, 30);
    run(1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 30);
    run(1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08, 2);
    run(1'b1, 32'hC0800000, 32'h0,        32'h7FC00000, 5'h10, 2);
    run(1'b0, 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'h05, 30);
    run(1'b0, 32'h00800000, 32'h4B000000, 32'h00000000, 5'h03, 30);
    run(1'b1, 32'h40800000, 32'h0,        32'h40000000, 5'h00, 30);
    run(1'b1, 32'h80000000, 32'h0,        32'h80000000, 5'h00, 2);
    run(1'b0, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'h10, 2);
    run(1'b0, 32'h00000000, 32'h00000000, 32'h7FC00000, 5'h10, 2);
    run(1'b0, 32'hFF800000, 32'h40000000, 32'hFF800000, 5'h00, 2);
    run(1'b0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'h00, 2);
    run(1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'h10, 2);
    run(1'b0, 32'hC0C00000, 32'h40000000, 32'hC0400000, 5'h00, 30);
    run(1'b1, 32'h7F800000, 32'h0,        32'h7F800000, 5'h00, 2);
    run(1'b0, 32'h00400000, 32'h3F800000, 32'h00000000, 5'h00, 2);
    run(1'b0, 32'h3F800000, 32'h7F800000, 32'h00000000, 5'h00, 2);
    run(1'b0, 32'h3F800000, 32'h3F7FFFFF, 32'h3F800001, 5'h01, 30);
    run(1'b1, 32'hBF800000, 32'h0,        32'h7FC00000, 5'h10, 2);
    run(1'b0, 32'h3F800000, 32'h80000000, 32'hFF800000, 5'h08, 2);

    // START while busy must be dropped; any extra VALID trips the monitor
    issue(1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 30);
    repeat (4) @(negedge clk);
    start = 1'b1;
    d1    = 32'h3F800000;
    d2    = 32'h40400000;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // Reset mid-operation: no VALID, outputs cleared, fresh START completes 30 cycles later
    start = 1'b1;
    op    = 1'b0;
    d1    = 32'h40C00000;
    d2    = 32'h40000000;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_valid", {31'd0, valid}, 32'd0);
    check("rstmid_result", result, 32'd0);
    check("rstmid_flags", {27'd0, flags}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 30);

`ifdef FPU_DIVSQRT_ABORT_EN
    start = 1'b1;
    op    = 1'b0;
    d1    = 32'h40C00000;
    d2    = 32'h40000000;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", result, last_res);
    issue(1'b1, 32'h40000000, 32'h0, 32'h3FB504F3, 5'h01, 30);
    drain();
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
